int16_to_float: RTL and testbench
=================================

Name: int16_to_float

Overview:
- Inverse of the float-to-int16 quantiser in the light_nn datapath.
- Takes a 16-bit offset-binary fixed-point code, code = (x + 1024) * 32 truncated, and returns the IEEE-754 single-precision value x = (code - 32768) / 32.
- Sits downstream of the int16 activation/weight storage and feeds fp_adder / floating_point_multiplier.
- Normalises iteratively, one left shift per cycle, behind valid/ready handshakes.

Parameters:
- OFFSET, 16'h8000, offset subtracted from the code (1024 * 32).
- FRAC_BITS, 5, fractional bits of the code (scale 2^5 = 32); legal range 0..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_code is valid.
- in_ready  out  1  block can accept a code.
- in_code  in  16  offset-binary fixed-point input.
- out_valid  out  1  out_float is valid.
- out_ready  in  1  consumer accepts out_float.
- out_float  out  32  IEEE-754 single result.
- busy  out  1  high in NORM or DONE.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, in_ready=1, out_valid=0, out_float=0, busy=0, internal mag/exp/sign=0.
- Reset mid-operation aborts the conversion; no output is produced.
- States are IDLE, NORM and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, compute v = in_code - OFFSET as a 17-bit signed value; sign = v<0; mag = |v| (16 bits; -32768 gives 0x8000).
  - If v==0: result=32'h0 (+0.0, never -0.0), go DONE.
  - Else: exp = 127 + 15 - FRAC_BITS, go NORM.
- NORM (in_ready=0):
  - If mag[15]==1: result = {sign, exp[7:0], mag[14:0], 8'b0}, go DONE.
  - Else: mag <= mag<<1, exp <= exp-1, stay.
  - Conversion is exact; no rounding is required.
- DONE:
  - out_valid=1 and out_float=result, both held stable until out_ready.
  - On out_valid&out_ready, go IDLE; out_valid=0 next cycle; out_float keeps its last value.
  - No same-cycle accept of a new input (in_ready=0 in DONE).
- Latency, counted in rising edges from the accept edge to out_valid high:
  - nonzero v: lz+2, where lz = leading zeros of mag (0..15); range 2..17.
  - v==0: 1.
- Throughput: one conversion at a time; minimum initiation interval is latency+1 with out_ready tied high.
- in_code is sampled only at the accept edge; later changes are ignored.
- in_valid while not ready: the input is not consumed and must be held by the producer.
- out_ready while out_valid=0: ignored.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_float=0; no accept occurs.
- Basic values, each -> out_float and latency:
  - in_code=16'h8020 -> 32'h3F800000 (+1.0), out_valid 12 edges after accept.
  - 16'h7FE0 -> 32'hBF800000 (-1.0).
  - 16'h0000 -> 32'hC4800000 (-1024.0), latency 2.
- Extremes and zero:
  - 16'hFFFF -> 32'h447FFE00 (1023.96875), latency 3.
  - 16'h8000 -> 32'h00000000, latency 1.
  - 16'h8001 -> 32'h3D000000 (0.03125), latency 17.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_float stable, in_ready=0, a new in_valid is not consumed; assert out_ready -> IDLE next cycle, pending input accepted that cycle.
- Mid-operation reset: accept 16'h8001, pull rst_n low at NORM cycle 5 -> next edge IDLE with out_valid=0; the following conversion of 16'h8020 is correct.
- Round-trip sweep: all 65536 codes through this block then float_to_int16 -> every code reproduced exactly; checker compares against a reference model of (code-32768)/32.

Source files
------------

// File: rtl/int16_to_float.sv
// int16_to_float: converts a 16-bit offset-binary fixed-point code into an
// IEEE-754 single-precision value.
//   value = (in_code - OFFSET) / 2^FRAC_BITS
// Normalisation is iterative: one left shift per cycle until the magnitude MSB
// is set, so latency depends on the leading-zero count of the magnitude.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_code is valid
//   in_ready   block can accept a code (IDLE only)
//   in_code    offset-binary fixed-point input
//   out_valid  out_float is valid (DONE only)
//   out_ready  consumer accepts out_float
//   out_float  IEEE-754 single result, holds its last value after hand-off
//   busy       high while a conversion is in flight or waiting for hand-off
module int16_to_float #(
    parameter logic [15:0] OFFSET    = 16'h8000,
    parameter int unsigned FRAC_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_float,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StNorm, StDone} state_e;

    // Exponent of a value whose magnitude MSB sits at bit 15.
    localparam logic [7:0] ExpInit = 8'(127 + 15 - FRAC_BITS);

    state_e      state_q, state_d;
    logic [15:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;

    logic [16:0] diff;
    logic [15:0] diff_mag;

    // 17-bit subtraction keeps the sign; -32768 negates to 0x8000 as required.
    assign diff     = {1'b0, in_code} - {1'b0, OFFSET};
    assign diff_mag = diff[16] ? (~diff[15:0] + 16'd1) : diff[15:0];

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d = diff[16];
                    mag_d  = diff_mag;
                    exp_d  = ExpInit;
                    if (diff == 17'd0) begin
                        // Zero is always +0.0.
                        result_d = 32'h0000_0000;
                        state_d  = StDone;
                    end else begin
                        state_d = StNorm;
                    end
                end
            end
            StNorm: begin
                if (mag_q[15]) begin
                    // Hidden bit dropped; 15 remaining bits fit exactly.
                    result_d = {sign_q, exp_q, mag_q[14:0], 8'b0};
                    state_d  = StDone;
                end else begin
                    mag_d = {mag_q[14:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mag_q    <= 16'd0;
            exp_q    <= 8'd0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_float = result_q;

endmodule

// File: tb/tb_int16_to_float.sv
// Self-checking bench for int16_to_float: directed vector table with
// hand-computed results and latencies, a strided sweep against a real-number
// model, and hand-written backpressure and mid-operation reset sequences.
module tb_int16_to_float;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        busy;

    int n_cmp;
    int n_err;

    int16_to_float #(
        .OFFSET    (16'h8000),
        .FRAC_BITS (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] code;
        logic [31:0] flt;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact real value, repacked from double to single bits.
    function automatic logic [31:0] ref_float(input logic [15:0] code);
        int          v;
        real         r;
        logic [63:0] d;
        logic [10:0] e11;
        logic [7:0]  e8;
        v = int'(code) - 32768;
        if (v == 0) return 32'h0;
        r   = real'(v) / 32.0;
        d   = $realtobits(r);
        e11 = d[62:52] - 11'd896;
        e8  = e11[7:0];
        return {d[63], e8, d[51:29]};
    endfunction

    // Accept at the next edge, count edges until out_valid, then hand off.
    task automatic convert(input logic [15:0] code, output logic [31:0] flt, output int lat);
        in_code  = code;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_code  = 16'h1234;  // must be ignored after the accept edge
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        flt = out_float;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_handoff", {31'd0, out_valid}, 32'd0);
    endtask

    vec_t        vecs[13];
    logic [31:0] flt;
    int          lat;
    logic [31:0] held;

    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs[0]  = '{16'h8020, 32'h3F80_0000, 12};
        vecs[1]  = '{16'h7FE0, 32'hBF80_0000, 12};
        vecs[2]  = '{16'h0000, 32'hC480_0000, 2};
        vecs[3]  = '{16'hFFFF, 32'h447F_FE00, 3};
        vecs[4]  = '{16'h8000, 32'h0000_0000, 1};
        vecs[5]  = '{16'h8001, 32'h3D00_0000, 17};
        vecs[6]  = '{16'h7FFF, 32'hBD00_0000, 17};
        vecs[7]  = '{16'h8040, 32'h4000_0000, 11};
        vecs[8]  = '{16'h8030, 32'h3FC0_0000, 12};
        vecs[9]  = '{16'h9000, 32'h4300_0000, 5};
        vecs[10] = '{16'h7000, 32'hC300_0000, 5};
        vecs[11] = '{16'h8010, 32'h3F00_0000, 13};
        vecs[12] = '{16'h0001, 32'hC47F_FE00, 3};

        // Reset held with in_valid high: nothing may be accepted.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_code   = 16'h8020;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_in_ready", {31'd0, in_ready}, 32'd1);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_out_float", out_float, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 13; i++) begin
            convert(vecs[i].code, flt, lat);
            check($sformatf("vec%0d_float", i), flt, vecs[i].flt);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Strided sweep against the real-number model.
        for (int i = 0; i < 64; i++) begin
            logic [15:0] c;
            c = 16'((i * 1031 + 7) % 65536);
            convert(c, flt, lat);
            check($sformatf("sweep_%h", c), flt, ref_float(c));
        end

        // Backpressure: result held, new input not consumed until hand-off.
        in_code  = 16'h8020;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_code = 16'h9000;  // stays valid as the pending next input
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd12);
        check("bp_float", out_float, 32'h3F80_0000);
        held = out_float;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_hold_float", out_float, held);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_float_kept", out_float, 32'h3F80_0000);
        @(posedge clk); #1;  // pending input accepted here
        in_valid = 1'b0;
        check("bp_pending_busy", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_pending_latency", 32'(lat), 32'd5);
        check("bp_pending_float", out_float, 32'h4300_0000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Mid-operation reset aborts a long conversion.
        in_code  = 16'h8001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_float", out_float, 32'd0);
        convert(16'h8020, flt, lat);
        check("post_rst_float", flt, 32'h3F80_0000);
        check("post_rst_latency", 32'(lat), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
